// File: rtl/moving_average_pkg.sv
// Shared types and helpers for the moving-average scheduler: default sample
// width, channel-ID width function and the result tag carried alongside the datapath.
package moving_average_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int CH_ID_W_MAX = 3;

    function automatic int ch_id_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Channel field is sized for the largest supported NUM_CH; upper bits stay zero.
    typedef struct packed {
        logic                   valid;
        logic [CH_ID_W_MAX-1:0] ch;
        logic                   warm;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating priority pointer, one-hot grant and encoded
// index; the pointer moves just past the winner whenever a grant is issued.
module rr_arbiter
    import moving_average_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_ID_W = ch_id_w(NUM_CH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic [NUM_CH-1:0]  req_i,
    output logic [NUM_CH-1:0]  grant_o,
    output logic [CH_ID_W-1:0] idx_o,
    output logic               valid_o
);

    logic [CH_ID_W-1:0] ptr_q, ptr_d;

    // Search upward from the pointer with wrap; flush suppresses every grant.
    always_comb begin
        int cand;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        if (!flush_i) begin
            for (int off = 0; off < NUM_CH; off++) begin
                cand = (int'(ptr_q) + off) % NUM_CH;
                if (!valid_o && req_i[cand]) begin
                    valid_o       = 1'b1;
                    grant_o[cand] = 1'b1;
                    idx_o         = CH_ID_W'(cand);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
        end else if (valid_o) begin
            ptr_d = CH_ID_W'((int'(idx_o) + 1) % NUM_CH);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/moving_average_scheduler.sv
// Shares one context-switched moving-average datapath between NUM_CH producers.
// Optional build macro MA_SCHED_STATS_EN adds per-channel 16-bit grant counters.
module moving_average_scheduler
    import moving_average_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DP_LATENCY = 2,
    parameter int WINDOW     = 4,
    localparam int CH_ID_W   = ch_id_w(NUM_CH)
) (
    input  logic                     system1000,
    input  logic                     system1000_rstn,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        req_ready,
    output logic                     dp_valid,
    output logic [CH_ID_W-1:0]       dp_ch,
    output logic [DATA_W-1:0]        dp_in,
    input  logic [DATA_W-1:0]        dp_out,
    output logic                     res_valid,
    output logic [CH_ID_W-1:0]       res_ch,
    output logic [DATA_W-1:0]        res_data,
    output logic                     res_warm
`ifdef MA_SCHED_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]     stat_grants
`endif
);

    localparam int CNT_W = $clog2(WINDOW + 1);

    logic               transfer;
    logic [CH_ID_W-1:0] grantIdx;
    logic [DATA_W-1:0]  grantData;
    logic               grantWarm;
    tag_t               newTag;

    logic [CNT_W-1:0]   warmCnt_q [NUM_CH];
    logic [CNT_W-1:0]   warmCnt_d [NUM_CH];
    tag_t               tag_q [DP_LATENCY+1];
    tag_t               tag_d [DP_LATENCY+1];
    logic [CH_ID_W-1:0] dpCh_q, dpCh_d;
    logic [DATA_W-1:0]  dpIn_q, dpIn_d;
    logic               resValid_q, resValid_d;
    logic [CH_ID_W-1:0] resCh_q, resCh_d;
    logic [DATA_W-1:0]  resData_q, resData_d;
    logic               resWarm_q, resWarm_d;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk_i   (system1000),
        .rst_ni  (system1000_rstn),
        .flush_i (flush),
        .req_i   (req_valid),
        .grant_o (req_ready),
        .idx_o   (grantIdx),
        .valid_o (transfer)
    );

    assign grantData = req_data[int'(grantIdx)*DATA_W +: DATA_W];
    assign grantWarm = (int'(warmCnt_q[grantIdx]) + 1) >= WINDOW;

    // Stage 0 of the tag pipe is the issue stage; stage DP_LATENCY lines up with dp_out.
    always_comb begin
        newTag                    = '0;
        newTag.valid              = transfer;
        newTag.ch[CH_ID_W-1:0]    = grantIdx;
        newTag.warm               = grantWarm;
        warmCnt_d                 = warmCnt_q;
        tag_d[0]                  = newTag;
        for (int k = 1; k <= DP_LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        dpCh_d     = dpCh_q;
        dpIn_d     = dpIn_q;
        resValid_d = tag_q[DP_LATENCY].valid;
        resCh_d    = resCh_q;
        resData_d  = resData_q;
        resWarm_d  = resWarm_q;
        if (transfer) begin
            dpCh_d = grantIdx;
            dpIn_d = grantData;
            if (int'(warmCnt_q[grantIdx]) < WINDOW) begin
                warmCnt_d[grantIdx] = warmCnt_q[grantIdx] + CNT_W'(1);
            end
        end
        if (tag_q[DP_LATENCY].valid) begin
            resCh_d   = tag_q[DP_LATENCY].ch[CH_ID_W-1:0];
            resData_d = dp_out;
            resWarm_d = tag_q[DP_LATENCY].warm;
        end
        if (flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
                warmCnt_d[c] = '0;
            end
            for (int k = 0; k <= DP_LATENCY; k++) begin
                tag_d[k] = '0;
            end
            dpCh_d     = '0;
            dpIn_d     = '0;
            resValid_d = 1'b0;
            resCh_d    = '0;
            resData_d  = '0;
            resWarm_d  = 1'b0;
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                warmCnt_q[c] <= '0;
            end
            for (int k = 0; k <= DP_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            dpCh_q     <= '0;
            dpIn_q     <= '0;
            resValid_q <= 1'b0;
            resCh_q    <= '0;
            resData_q  <= '0;
            resWarm_q  <= 1'b0;
        end else begin
            warmCnt_q  <= warmCnt_d;
            tag_q      <= tag_d;
            dpCh_q     <= dpCh_d;
            dpIn_q     <= dpIn_d;
            resValid_q <= resValid_d;
            resCh_q    <= resCh_d;
            resData_q  <= resData_d;
            resWarm_q  <= resWarm_d;
        end
    end

    assign dp_valid  = tag_q[0].valid;
    assign dp_ch     = dpCh_q;
    assign dp_in     = dpIn_q;
    assign res_valid = resValid_q;
    assign res_ch    = resCh_q;
    assign res_data  = resData_q;
    assign res_warm  = resWarm_q;

`ifdef MA_SCHED_STATS_EN
    logic [15:0] statCnt_q [NUM_CH];

    // Counters wrap naturally at 2^16.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                statCnt_q[c] <= '0;
            end
        end else if (flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
                statCnt_q[c] <= '0;
            end
        end else if (transfer) begin
            statCnt_q[grantIdx] <= statCnt_q[grantIdx] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_stat
        assign stat_grants[g*16 +: 16] = statCnt_q[g];
    end
`endif

endmodule

// File: tb/tb_moving_average_scheduler.sv
// Self-checking bench for moving_average_scheduler: table-driven arbitration
// vectors, hand-written corner sequences and random traffic against a queue model.
module tb_moving_average_scheduler;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int DP_LAT = 2;
    localparam int WINDOW = 4;

    logic                     system1000 = 1'b0;
    logic                     system1000_rstn = 1'b0;
    logic                     flush = 1'b0;
    logic [NUM_CH-1:0]        req_valid = '0;
    logic [NUM_CH*DATA_W-1:0] req_data = '0;
    logic [NUM_CH-1:0]        req_ready;
    logic                     dp_valid;
    logic [1:0]               dp_ch;
    logic [DATA_W-1:0]        dp_in;
    logic [DATA_W-1:0]        dp_out;
    logic                     res_valid;
    logic [1:0]               res_ch;
    logic [DATA_W-1:0]        res_data;
    logic                     res_warm;
`ifdef MA_SCHED_STATS_EN
    logic [NUM_CH*16-1:0]     stat_grants;
`endif

    moving_average_scheduler #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DP_LATENCY(DP_LAT), .WINDOW(WINDOW)
    ) dut (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .flush           (flush),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .dp_valid        (dp_valid),
        .dp_ch           (dp_ch),
        .dp_in           (dp_in),
        .dp_out          (dp_out),
        .res_valid       (res_valid),
        .res_ch          (res_ch),
        .res_data        (res_data),
        .res_warm        (res_warm)
`ifdef MA_SCHED_STATS_EN
        ,
        .stat_grants     (stat_grants)
`endif
    );

    always #5 system1000 = ~system1000;

    // Stand-in datapath: result is the issued sample XOR 0x5A, DP_LAT cycles later.
    logic [DATA_W-1:0] dpPipe [DP_LAT];
    always @(posedge system1000) begin
        dpPipe[0] <= dp_in ^ 8'h5A;
        for (int k = 1; k < DP_LAT; k++) dpPipe[k] <= dpPipe[k-1];
    end
    assign dp_out = dpPipe[DP_LAT-1];

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       warm;
        int         due;
    } expRes_t;

    typedef struct {
        logic [3:0] valid;
        logic       fl;
        logic [3:0] grant;
    } vec_t;

    int         checks = 0;
    int         fails = 0;
    int         cycle = 0;
    int         modelPtr;
    int         modelCnt [NUM_CH];
    expRes_t    expQ [$];
    expRes_t    resLog [$];
    logic       expDpValid;
    logic [1:0] expDpCh;
    logic [7:0] expDpIn;
    vec_t       vecs [$];
    logic [3:0] g;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic void resetModel();
        modelPtr = 0;
        foreach (modelCnt[i]) modelCnt[i] = 0;
        expQ.delete();
        expDpValid = 1'b0;
        expDpCh    = '0;
        expDpIn    = '0;
    endfunction

    // One clock: drive inputs, check registered outputs and the grant, advance the model.
    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic fl,
                                 output logic [3:0] expGrant);
        int      gi;
        expRes_t e;
        @(posedge system1000);
        cycle++;
        #1;
        req_valid = v;
        req_data  = d;
        flush     = fl;
        #4;
        checkOutput("dp_valid", 32'(dp_valid), 32'(expDpValid));
        checkOutput("dp_ch", 32'(dp_ch), 32'(expDpCh));
        checkOutput("dp_in", 32'(dp_in), 32'(expDpIn));
        if (expQ.size() > 0 && expQ[0].due == cycle) begin
            e = expQ.pop_front();
            checkOutput("res_valid", 32'(res_valid), 32'd1);
            checkOutput("res_ch", 32'(res_ch), 32'(e.ch));
            checkOutput("res_data", 32'(res_data), 32'(e.data));
            checkOutput("res_warm", 32'(res_warm), 32'(e.warm));
        end else begin
            checkOutput("res_valid", 32'(res_valid), 32'd0);
        end
        if (res_valid === 1'b1) begin
            resLog.push_back('{int'(res_ch), res_data, res_warm, cycle});
        end
        gi = -1;
        expGrant = '0;
        if (!fl) begin
            for (int off = 0; off < NUM_CH && gi < 0; off++) begin
                if (v[(modelPtr + off) % NUM_CH]) gi = (modelPtr + off) % NUM_CH;
            end
        end
        if (gi >= 0) expGrant[gi] = 1'b1;
        checkOutput("req_ready", 32'(req_ready), 32'(expGrant));
        if (fl) begin
            resetModel();
        end else if (gi >= 0) begin
            e.ch   = gi;
            e.data = d[8*gi +: 8] ^ 8'h5A;
            e.warm = (modelCnt[gi] + 1) >= WINDOW;
            e.due  = cycle + DP_LAT + 2;
            expQ.push_back(e);
            if (modelCnt[gi] < WINDOW) modelCnt[gi]++;
            modelPtr   = (gi + 1) % NUM_CH;
            expDpValid = 1'b1;
            expDpCh    = 2'(gi);
            expDpIn    = d[8*gi +: 8];
        end else begin
            expDpValid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        logic [3:0] gg;
        for (int i = 0; i < n; i++) applyStimulus(4'b0000, 32'h0, 1'b0, gg);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_dp_valid"}, 32'(dp_valid), 32'd0);
        checkOutput({tag, "_dp_ch"}, 32'(dp_ch), 32'd0);
        checkOutput({tag, "_dp_in"}, 32'(dp_in), 32'd0);
        checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        checkOutput({tag, "_res_ch"}, 32'(res_ch), 32'd0);
        checkOutput({tag, "_res_data"}, 32'(res_data), 32'd0);
        checkOutput({tag, "_res_warm"}, 32'(res_warm), 32'd0);
    endtask

    initial begin
        // Arbitration table: full load rotation, wrap from pointer 2, flush blocks grants.
        for (int i = 0; i < 8; i++) vecs.push_back('{4'b1111, 1'b0, 4'(4'b0001 << (i % 4))});
        vecs.push_back('{4'b0010, 1'b0, 4'b0010});
        vecs.push_back('{4'b1010, 1'b0, 4'b1000});
        vecs.push_back('{4'b1010, 1'b0, 4'b0010});
        for (int i = 0; i < 4; i++) vecs.push_back('{4'b0000, 1'b0, 4'b0000});
        vecs.push_back('{4'b1111, 1'b1, 4'b0000});

        resetModel();
        #12;
        checkResetOutputs("reset");
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge system1000);
        system1000_rstn = 1'b1;
        idle(5);

        resLog.delete();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, 32'h04030201, vecs[i].fl, g);
            checkOutput("tbl_grant", 32'(req_ready), 32'(vecs[i].grant));
        end
        checkOutput("rot_count", 32'(resLog.size()), 32'd11);
        for (int i = 0; i < 8 && i < resLog.size(); i++) begin
            checkOutput("rot_res_ch", 32'(resLog[i].ch), 32'(i % 4));
            checkOutput("rot_res_data", 32'(resLog[i].data), 32'(8'((i % 4) + 1) ^ 8'h5A));
        end

        // Single channel warms up after WINDOW samples; pointer parks just past it.
        resLog.delete();
        for (int i = 0; i < 5; i++) applyStimulus(4'b0100, 32'h00C0_0000 | 32'(i << 16), 1'b0, g);
        idle(6);
        checkOutput("ch2_count", 32'(resLog.size()), 32'd5);
        for (int i = 0; i < 5 && i < resLog.size(); i++) begin
            checkOutput("ch2_warm", 32'(resLog[i].warm), (i >= 3) ? 32'd1 : 32'd0);
        end
        applyStimulus(4'b1111, 32'h44332211, 1'b0, g);
        checkOutput("ptr_after_ch2", 32'(req_ready), 32'b1000);
        idle(6);

        // Flush with samples in flight: the tail is dropped and warm history restarts.
        for (int i = 0; i < 5; i++) applyStimulus(4'b0010, 32'h0000_7000 | 32'(i << 8), 1'b0, g);
        applyStimulus(4'b0010, 32'h0000_7F00, 1'b1, g);
        checkOutput("flush_ready", 32'(req_ready), 32'd0);
        resLog.delete();
        idle(8);
        checkOutput("flush_dropped", 32'(resLog.size()), 32'd0);
        applyStimulus(4'b0010, 32'h0000_6600, 1'b0, g);
        idle(6);
        checkOutput("post_flush_count", 32'(resLog.size()), 32'd1);
        if (resLog.size() > 0) begin
            checkOutput("post_flush_ch", 32'(resLog[0].ch), 32'd1);
            checkOutput("post_flush_warm", 32'(resLog[0].warm), 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 31) == 0), g);
        end
        idle(6);

        // Asynchronous reset while the pipe is full.
        for (int i = 0; i < 3; i++) applyStimulus(4'b1111, $urandom, 1'b0, g);
        @(posedge system1000);
        cycle++;
        #2;
        system1000_rstn = 1'b0;
        req_valid = '0;
        #1;
        checkResetOutputs("midreset");
        resetModel();
        @(negedge system1000);
        system1000_rstn = 1'b1;
        resLog.delete();
        idle(8);
        checkOutput("midreset_no_results", 32'(resLog.size()), 32'd0);

`ifdef MA_SCHED_STATS_EN
        applyStimulus(4'b0000, 32'h0, 1'b1, g);
        for (int i = 0; i < 70000; i++) applyStimulus(4'b0001, 32'h11, 1'b0, g);
        idle(1);
        checkOutput("stat_ch0", 32'(stat_grants[15:0]), 32'(70000 - 65536));
        checkOutput("stat_ch1", 32'(stat_grants[31:16]), 32'd0);
        checkOutput("stat_ch2", 32'(stat_grants[47:32]), 32'd0);
        checkOutput("stat_ch3", 32'(stat_grants[63:48]), 32'd0);
        idle(6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
